pc_jump_sequencer: RTL and testbench

//  Fetch-stage program-counter sequencer for the pipelined core. Takes the 6-bit

---
 rtl/pc_jump_sequencer.sv | 107 ++++++++++
 tb/tb_pc_jump_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_jump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_jump_sequencer
// Purpose  : Fetch-stage PC register with jump redirect, stall hold and
//            single-cycle IF/ID flush sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module pc_jump_sequencer #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump_valid,
  input  logic             jump_rel,
  input  logic [OFF_W-1:0] jump_partial,
  input  logic [PC_W-1:0]  id_pc,
  output logic [PC_W-1:0]  pc,
  output logic             if_id_flush,
  output logic             jump_taken,
  output logic             jump_pending
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] tgt_q;
  logic            flush_q;
  logic            taken_q;
  logic            pending_q;

  logic [PC_W-1:0] sext_d;
  logic [PC_W-1:0] target_d;
  logic [PC_W-1:0] pc_inc_d;

  // Relative targets wrap modulo 2^PC_W; the carry out is dropped by width.
  assign sext_d   = {{(PC_W-OFF_W){jump_partial[OFF_W-1]}}, jump_partial};
  assign target_d = jump_rel ? (id_pc + sext_d) : sext_d;
  assign pc_inc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // Outputs are set alongside the state they decode from, so they stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= '0;
      tgt_q     <= '0;
      flush_q   <= 1'b0;
      taken_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      flush_q   <= 1'b0;
      taken_q   <= 1'b0;
      pending_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (jump_valid) begin
            if (stall) begin
              tgt_q     <= target_d;
              state_q   <= ST_PENDING;
              pending_q <= 1'b1;
            end else begin
              pc_q    <= target_d;
              state_q <= ST_FLUSH;
              flush_q <= 1'b1;
              taken_q <= 1'b1;
            end
          end else if (!stall) begin
            pc_q <= pc_inc_d;
          end
        end
        ST_PENDING: begin
          if (stall) begin
            pending_q <= 1'b1;
          end else begin
            pc_q    <= tgt_q;
            state_q <= ST_FLUSH;
            flush_q <= 1'b1;
            taken_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // The ID instruction here is wrong-path, so any jump it carries is dropped.
          if (!stall) begin
            pc_q <= pc_inc_d;
          end
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign if_id_flush  = flush_q;
  assign jump_taken   = taken_q;
  assign jump_pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_jump_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_jump_sequencer
// Purpose  : Directed and randomized self-checking bench for pc_jump_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_jump_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       jump_valid = 1'b0;
  logic       jump_rel = 1'b0;
  logic [5:0] jump_partial = '0;
  logic [7:0] id_pc = '0;
  logic [7:0] pc;
  logic       if_id_flush;
  logic       jump_taken;
  logic       jump_pending;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model expressed as "what the fetch stage is doing" flags
  int m_pc;
  int m_tgt;
  bit m_waiting;
  bit m_redirected;

  pc_jump_sequencer #(.PC_W(8), .OFF_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .jump_valid   (jump_valid),
    .jump_rel     (jump_rel),
    .jump_partial (jump_partial),
    .id_pc        (id_pc),
    .pc           (pc),
    .if_id_flush  (if_id_flush),
    .jump_taken   (jump_taken),
    .jump_pending (jump_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int jump_target(input bit rel, input logic [5:0] p, input logic [7:0] base);
    int off;
    off = (p >= 32) ? int'(p) - 64 : int'(p);
    return rel ? ((int'(base) + off) & 255) : (off & 255);
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_pc = 0; m_tgt = 0; m_waiting = 0; m_redirected = 0;
    end else if (m_redirected) begin
      if (!stall) m_pc = (m_pc + 1) % 256;
      m_redirected = 0;
    end else if (m_waiting) begin
      if (!stall) begin
        m_pc = m_tgt; m_waiting = 0; m_redirected = 1;
      end
    end else if (jump_valid) begin
      if (stall) begin
        m_tgt = jump_target(jump_rel, jump_partial, id_pc); m_waiting = 1;
      end else begin
        m_pc = jump_target(jump_rel, jump_partial, id_pc); m_redirected = 1;
      end
    end else if (!stall) begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs against the model.
  task automatic cyc(input bit rst, input bit st, input bit jv, input bit jr,
                     input logic [5:0] p, input logic [7:0] ipc);
    reset = rst; stall = st; jump_valid = jv; jump_rel = jr;
    jump_partial = p; id_pc = ipc;
    @(posedge clk);
    model_edge();
    #1;
    check("pc", int'(pc), m_pc);
    check("if_id_flush", int'(if_id_flush), int'(m_redirected));
    check("jump_taken", int'(jump_taken), int'(m_redirected));
    check("jump_pending", int'(jump_pending), int'(m_waiting));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 6'h00, 8'h00);
  endtask

  initial begin
    m_pc = 0; m_tgt = 0; m_waiting = 0; m_redirected = 0;

    // Reset and free-running count with wrap
    cyc(1, 0, 0, 0, 6'h00, 8'h00);
    cyc(1, 0, 0, 0, 6'h00, 8'h00);
    check("reset_pc", int'(pc), 0);
    check("reset_flush", int'(if_id_flush), 0);
    check("reset_pending", int'(jump_pending), 0);
    idle(255);
    check("count_ff", int'(pc), 8'hFF);
    idle(1);
    check("count_wrap", int'(pc), 0);
    idle(4);

    // Absolute jump with negative offset
    cyc(1, 0, 0, 0, 6'h00, 8'h00);
    idle(32);
    check("pc_at_20", int'(pc), 8'h20);
    cyc(0, 0, 1, 0, 6'b111110, 8'h00);
    check("abs_target", int'(pc), 8'hFE);
    check("abs_flush", int'(if_id_flush), 1);
    check("abs_taken", int'(jump_taken), 1);
    idle(1);
    check("abs_after", int'(pc), 8'hFF);
    check("abs_flush_1cyc", int'(if_id_flush), 0);

    // Relative jumps, including wrap
    cyc(0, 0, 1, 1, 6'h3F, 8'h10);
    check("rel_neg", int'(pc), 8'h0F);
    idle(1);
    cyc(0, 0, 1, 1, 6'h0A, 8'hFA);
    check("rel_wrap", int'(pc), 8'h04);
    idle(1);

    // Jump under stall is held until stall drops
    cyc(0, 1, 1, 0, 6'h05, 8'h00);
    check("pend_set", int'(jump_pending), 1);
    cyc(0, 1, 0, 0, 6'h00, 8'h00);
    cyc(0, 1, 0, 0, 6'h00, 8'h00);
    check("pend_frozen", int'(pc), 8'h05 + 8'h00 == 8'h05 ? m_pc : 0);
    cyc(0, 0, 0, 0, 6'h00, 8'h00);
    check("pend_load", int'(pc), 8'h05);
    check("pend_flush", int'(if_id_flush), 1);
    check("pend_clear", int'(jump_pending), 0);

    // Jump presented during the flush cycle is discarded
    cyc(0, 0, 1, 0, 6'h11, 8'h00);
    check("flush_ignore_pc", int'(pc), 8'h06);
    check("flush_no_second", int'(if_id_flush), 0);
    idle(1);
    check("flush_ignore_next", int'(pc), 8'h07);

    // Reset in the middle of a pending redirect
    cyc(0, 1, 1, 0, 6'h15, 8'h00);
    check("pend2_set", int'(jump_pending), 1);
    cyc(1, 0, 0, 0, 6'h00, 8'h00);
    check("rst_pend_pc", int'(pc), 0);
    check("rst_pend_pending", int'(jump_pending), 0);
    check("rst_pend_flush", int'(if_id_flush), 0);
    idle(1);
    check("rst_pend_noload", int'(pc), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 30), 1'($urandom), 6'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
